uart_block_rx: RTL and testbench
================================

# uart_block_rx

Serial receive stage that feeds the AES controller's ReadSerial state. Deserialises UART frames from the Rx pin and assembles 16 bytes into a 128-bit block. It presents the block on Data and raises Ry, which drives the controller's SerialReadRy. Bytes are accepted only while the controller holds En (SerialReadEn) high.

## Interface
- CLKS_PER_BIT, default 434: Clk cycles per UART bit (50 MHz / 115200); must be ≥4.
- NBYTES, default 16: bytes per block.
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  reset Rst, synchronous, active-high; clock Clk.
- Rx  in  1  asynchronous UART line, idle high.
- En  in  1  receive enable from controller (SerialReadEn).
- Data  out  8*NBYTES  assembled block; first received byte in Data[8*NBYTES-1 -: 8].
- Ry  out  1  block complete, to controller SerialReadRy.
- Err  out  1  one-cycle pulse on a discarded malformed byte.

## Operation
- Rx passes through a 2-flop synchroniser, both flops reset to 1. All sampling uses the synchronised signal rxs.
- Bit FSM states:
  - IDLE: rxs==0 → START, bit timer cleared.
  - START: at timer==CLKS_PER_BIT/2-1, sample rxs. If 1 (glitch) → IDLE with no Err. If 0 → DATA, timer cleared.
  - DATA: sample one bit every CLKS_PER_BIT cycles, LSB first, 8 bits. Then → PARITY if configured, else → STOP.
  - PARITY (only with UART_RX_PARITY_EN): sample one bit after CLKS_PER_BIT cycles → STOP.
  - STOP: sample one bit after CLKS_PER_BIT cycles.
    - Stop bit 0, or parity mismatch: Err pulses, byte discarded.
    - Otherwise the byte is valid.
    - FSM → IDLE on the sample cycle without waiting for the full stop bit.
- Block assembly, using byte counter cnt (0..NBYTES-1) and shadow register shreg:
  - A valid byte with En=1 and Ry=0 is shifted into shreg: shreg <= {shreg[8*NBYTES-9:0], byte}, and cnt increments.
  - When the NBYTES-th byte is accepted: Data <= the new shreg value, Ry <= 1, cnt <= 0.
  - Valid bytes arriving with En=0 or Ry=1 are discarded with no Err.
  - En=0 clears cnt and Ry on the next edge. shreg and Data are not cleared.
- Data changes only on block completion. It stays stable while downstream key/enc/dec stages run.
- Err is independent of En. Framing errors are always reported.

## Timing
- Reset values: Data=0, Ry=0, Err=0, FSM=IDLE, cnt=0, synchroniser=1.
- Rst mid-frame or mid-block aborts everything, and the partial block is lost.
- Let t be the first edge at which rxs==0 in IDLE. Sampling edges:
  - Start bit: t+CLKS_PER_BIT/2.
  - Data bit n (0..7): t+CLKS_PER_BIT/2+(n+1)·CLKS_PER_BIT.
  - Parity bit: t+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - Stop bit: t+CLKS_PER_BIT/2+9·CLKS_PER_BIT, or +10·CLKS_PER_BIT with parity.
- Rx pin to rxs latency is 2 cycles.
- Ry and Data update one cycle after the stop-bit sample of the last byte.
- Err is high exactly for the cycle after the bad stop/parity sample.
- Ry is a level, held until the first edge at which En=0. It falls one cycle after En falls.
- If En falls on the same edge the last byte completes, the byte is discarded, Ry stays 0 and cnt is 0.
- A new start bit may be detected on the cycle after the stop sample. Back-to-back frames require no idle gap.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1. Even parity is checked over the 8 data bits; a mismatch pulses Err and discards the byte.
- UART_RX_PARITY_EN undefined: frame is 8N1. No PARITY state exists, and frame length is 10 bits.

## Test plan
1. CLKS_PER_BIT=4, En=1: send bytes 0x00..0x0F as 8N1 frames. Required: Ry rises 1 cycle after the 16th stop sample, and Data=128'h000102030405060708090A0B0C0D0E0F.
2. Hold En=1 after Ry. Send 3 more bytes, then drop En. Required: Data unchanged, Ry falls 1 cycle after En falls. A fresh 16 bytes then produce a new block containing none of the 3 extra bytes.
3. Send byte 0xA5 with stop bit 0 mid-block. Required: one-cycle Err pulse, cnt unchanged. A block of 16 further good bytes completes with no 0xA5 in Data.
4. Drive Rx low for 1 cycle (shorter than half a bit) while idle. Required: FSM returns to IDLE, no Err, cnt unchanged.
5. Assert Rst after 7 bytes, then send 16 bytes. Required: Ry=0 and Data=0 during reset. The block equals the 16 post-reset bytes only.
6. With UART_RX_PARITY_EN defined, send 0x03 with parity 1 (wrong). Required: Err pulse, byte discarded. Sending 0x03 with parity 0 is accepted.

Source files
------------

// File: rtl/uart_block_rx.sv
// UART receiver that deserialises frames on Rx and packs NBYTES bytes into one block on Data.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 frames with even parity checking (default 8N1).
module uart_block_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NBYTES       = 16,
  localparam int CW          = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Rx,
  input  logic                En,
  output logic [8*NBYTES-1:0] Data,
  output logic                Ry,
  output logic                Err,
  output logic [2:0]          fsm_state,
  output logic [CW-1:0]       byte_cnt
);
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP  = 3'd3
  } state_t;

  state_t              state, state_next;
  logic                rx_meta, rxs;
  logic [TW-1:0]       timer;
  logic [2:0]          bit_idx;
  logic [7:0]          rx_byte;
  logic                half_tick, full_tick;
  logic                timer_clr, bit_sample, stop_sample;
  logic                par_bad, byte_ok;
  logic [CW-1:0]       cnt;
  logic [8*NBYTES-1:0] shreg, shifted;

  always_ff @(posedge Clk) begin
    if (Rst) {rx_meta, rxs} <= 2'b11;
    else     {rx_meta, rxs} <= {Rx, rx_meta};
  end

  assign half_tick = (timer == TW'(CLKS_PER_BIT / 2 - 1));
  assign full_tick = (timer == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!rxs) state_next = START;
      START:  if (half_tick) state_next = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (full_tick && bit_idx == 3'd7) state_next = PARITY;
      PARITY: if (full_tick) state_next = STOP;
`else
      DATA:   if (full_tick && bit_idx == 3'd7) state_next = STOP;
`endif
      STOP:   if (full_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_sample;
`endif

  always_comb begin
    timer_clr   = 1'b0;
    bit_sample  = 1'b0;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample  = 1'b0;
`endif
    case (state)
      IDLE:  timer_clr = 1'b1;
      START: timer_clr = half_tick;
      DATA: begin
        bit_sample = full_tick;
        timer_clr  = full_tick;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_sample = full_tick;
        timer_clr  = full_tick;
      end
`endif
      STOP: begin
        stop_sample = full_tick;
        timer_clr   = full_tick;
      end
      default: timer_clr = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      timer   <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      timer <= timer_clr ? '0 : timer + TW'(1);
      if (state == START)  bit_idx <= '0;
      else if (bit_sample) bit_idx <= bit_idx + 3'd1;
      if (bit_sample) rx_byte <= {rxs, rx_byte[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  always_ff @(posedge Clk) begin
    if (Rst)             par_bad <= 1'b0;
    else if (par_sample) par_bad <= (rxs != ^rx_byte);
  end
`else
  assign par_bad = 1'b0;
`endif

  assign byte_ok = stop_sample && rxs && !par_bad;

  always_ff @(posedge Clk) begin
    if (Rst) Err <= 1'b0;
    else     Err <= stop_sample && !byte_ok;
  end

  assign shifted = (shreg << 8) | (8*NBYTES)'(rx_byte);

  // Ry/En handshake: Ry holds a finished block until En drops; while Ry is high no byte is taken,
  // and En low abandons any partial block.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shreg <= '0;
      Data  <= '0;
      Ry    <= 1'b0;
      cnt   <= '0;
    end else if (!En) begin
      cnt <= '0;
      Ry  <= 1'b0;
    end else if (byte_ok && !Ry) begin
      shreg <= shifted;
      if (cnt == CW'(NBYTES - 1)) begin
        Data <= shifted;
        Ry   <= 1'b1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign fsm_state = state;
  assign byte_cnt  = cnt;
endmodule

// File: tb/tb_uart_block_rx.sv
// Directed bench for uart_block_rx: framed bytes from tables, hand sequences for En, glitch and reset.
module tb_uart_block_rx;
  localparam int CPB = 4;
  localparam int NB  = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, rx, en;
  logic [127:0] data;
  logic         ry, err;
  logic [2:0]   fsm_state;
  logic [3:0]   byte_cnt;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       par_bad;
    logic       exp_err;
    logic       exp_ry;
    int         exp_cnt;
  } vec_t;

  vec_t         tbl[$];
  logic [7:0]   exp_q[$];
  logic [127:0] model_data;
  logic         model_ry;
  logic [127:0] exp_c;
  int           n_vec = 0;
  int           n_fail = 0;
  int           err_cnt = 0;
  int           err_snap;

  uart_block_rx #(.CLKS_PER_BIT(CPB), .NBYTES(NB)) dut (
    .Clk(clk), .Rst(rst), .Rx(rx), .En(en),
    .Data(data), .Ry(ry), .Err(err),
    .fsm_state(fsm_state), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (err) err_cnt <= err_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR) send_bit((^b) ^ par_bad);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic add(input logic [7:0] b, input logic stop, input logic par_bad,
                     input logic e, input logic r, input int c);
    vec_t v;
    v.b = b; v.stop = stop; v.par_bad = par_bad;
    v.exp_err = e; v.exp_ry = r; v.exp_cnt = c;
    tbl.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    send_frame(v.b, v.stop, v.par_bad);
    check("ry_before_stop", ry, model_ry);
    @(posedge clk); #1;
    check("err", err, v.exp_err);
    check("ry", ry, v.exp_ry);
    check("cnt", byte_cnt, v.exp_cnt);
    if (!v.exp_err && !model_ry) exp_q.push_back(v.b);
    if (v.exp_ry && !model_ry) begin
      model_data = '0;
      foreach (exp_q[i]) model_data = {model_data[119:0], exp_q[i]};
      exp_q.delete();
    end
    model_ry = v.exp_ry;
    check("data", data, model_data);
    if (v.exp_err) begin
      @(posedge clk); #1;
      check("err_width", err, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_tbl();
    foreach (tbl[i]) apply_vec(tbl[i]);
    tbl.delete();
  endtask

  task automatic drop_en();
    en = 1'b0;
    check("ry_hold", ry, model_ry);
    @(posedge clk); #1;
    check("ry_fall", ry, 1'b0);
    check("cnt_clr", byte_cnt, 0);
    check("data_hold", data, model_data);
    model_ry = 1'b0;
    exp_q.delete();
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rx = 1'b1;
    model_data = '0; model_ry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_ry", ry, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", fsm_state, 0);
    check("rst_cnt", byte_cnt, 0);
    rst = 1'b0; en = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Block of 0x00..0x0F, then three extra bytes ignored while Ry is high.
    for (int i = 0; i < 16; i++) add(8'(i), 1'b1, 1'b0, 1'b0, i == 15, (i == 15) ? 0 : i + 1);
    for (int i = 0; i < 3; i++)  add(8'hE0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b1, 0);
    apply_tbl();
    check("block_a", data, 128'h000102030405060708090A0B0C0D0E0F);
    drop_en();

    // Framing error (and parity error if built) in the middle of a block.
    for (int i = 0; i < 5; i++) add(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, i + 1);
    add(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    if (PAR) add(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 5);
    for (int i = 5; i < 16; i++) add(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, i == 15, (i == 15) ? 0 : i + 1);
    apply_tbl();
    check("block_b", data, 128'h101112131415161718191A1B1C1D1E1F);
    drop_en();

    // Seven bytes of a block that the reset below will discard.
    for (int i = 0; i < 7; i++) add(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, i + 1);
    apply_tbl();

    // One-cycle low glitch while idle.
    err_snap = err_cnt;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_start", fsm_state, 1);
    repeat (2) @(posedge clk);
    #1;
    check("glitch_idle", fsm_state, 0);
    check("glitch_cnt", byte_cnt, 7);
    check("glitch_no_err", err_cnt, err_snap);

    // Reset in the middle of a frame.
    rx = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_data", data, 0);
    check("mid_rst_ry", ry, 1'b0);
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_cnt", byte_cnt, 0);
    rx = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_data = '0; model_ry = 1'b0; exp_q.delete();
    repeat (4) @(posedge clk);
    #1;

    // Post-reset block; with parity the first byte is 0x03 carrying correct parity.
    for (int i = 0; i < 16; i++)
      add((i == 0 && PAR) ? 8'h03 : 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0, i == 15, (i == 15) ? 0 : i + 1);
    apply_tbl();
    exp_c = 128'h303132333435363738393A3B3C3D3E3F;
    if (PAR) exp_c[127:120] = 8'h03;
    check("block_c", data, exp_c);
    drop_en();

    // En falls on the same edge as the last byte completes.
    for (int i = 0; i < 15; i++) add(8'h40 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, i + 1);
    apply_tbl();
    send_frame(8'h4F, 1'b1, 1'b0);
    en = 1'b0;
    @(posedge clk); #1;
    check("late_en_ry", ry, 1'b0);
    check("late_en_cnt", byte_cnt, 0);
    check("late_en_err", err, 1'b0);
    check("late_en_data", data, exp_c);
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("late_en_ry_stays", ry, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
